// File: rtl/truth_table_probe_if.sv
// rtl/truth_table_probe_if.sv - probe control, stimulus and result signals
interface truth_table_probe_if;
    logic        start;
    logic [15:0] expected;
    logic        f;
    logic [3:0]  x;
    logic        busy;
    logic        done;
    logic [15:0] truth_tbl;
    logic [4:0]  mismatch_cnt;
    logic        mismatch;
    logic [3:0]  first_bad;

    modport master (
        output start, expected, f,
        input  x, busy, done, truth_tbl, mismatch_cnt, mismatch, first_bad
    );

    modport slave (
        input  start, expected, f,
        output x, busy, done, truth_tbl, mismatch_cnt, mismatch, first_bad
    );
endinterface

// File: rtl/truth_table_probe.sv
// rtl/truth_table_probe.sv - sweeps x over 0..15, captures f and compares with a latched golden table
module truth_table_probe #(
    parameter int unsigned SETTLE = 1
) (
    input  logic               clk,
    input  logic               areset_n,
    truth_table_probe_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [3:0] SETTLE_V = 4'(SETTLE);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_wait;
    logic [3:0]  r_x;
    logic [15:0] r_exp;
    logic [15:0] r_tbl;
    logic [4:0]  r_cnt;
    logic [3:0]  r_fb;
    logic        r_busy;
    logic        r_done;
    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic        w_accept;
    logic        w_sample;
    logic        w_last;
    logic        w_miss;

    assign w_accept = (r_state == S_IDLE) && bus.start;
    assign w_sample = (r_state == S_RUN) && (r_wait == 4'd1);
    assign w_last   = w_sample && (r_x == 4'd15);
    assign w_miss   = bus.f != r_exp[r_x];

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next-cycle busy/done decoded from the next state, then registered below.
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            S_RUN:   w_busy_nxt = 1'b1;
            S_DONE:  w_done_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_wait <= 4'd0;
            r_x    <= 4'd0;
            r_exp  <= 16'd0;
            r_tbl  <= 16'd0;
            r_cnt  <= 5'd0;
            r_fb   <= 4'd0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            if (w_accept) begin
                r_exp  <= bus.expected;
                r_tbl  <= 16'd0;
                r_cnt  <= 5'd0;
                r_fb   <= 4'd0;
                r_x    <= 4'd0;
                r_wait <= SETTLE_V;
            end else if (r_state == S_RUN) begin
                if (!w_sample) begin
                    r_wait <= r_wait - 4'd1;
                end else begin
                    r_tbl[r_x] <= bus.f;
                    if (w_miss) begin
                        r_cnt <= r_cnt + 5'd1;
                        // A zero count means no earlier index of this sweep mismatched.
                        if (r_cnt == 5'd0) r_fb <= r_x;
                    end
                    if (w_last) begin
                        r_x <= 4'd0;
                    end else begin
                        r_x    <= r_x + 4'd1;
                        r_wait <= SETTLE_V;
                    end
                end
            end
        end
    end

    assign bus.x            = r_x;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.truth_tbl    = r_tbl;
    assign bus.mismatch_cnt = r_cnt;
    assign bus.mismatch     = |r_cnt;
    assign bus.first_bad    = r_fb;

endmodule

// File: tb/tb_truth_table_probe.sv
// tb/tb_truth_table_probe.sv - scoreboard bench for truth_table_probe
module tb_truth_table_probe;

    logic        clk = 1'b0;
    logic        areset_n = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          fmode1 = 0;
    logic [15:0] ref_tbl = 16'hD073;

    typedef struct {
        logic [15:0] tbl;
        logic [4:0]  cnt;
        logic [3:0]  fb;
        int          start_cyc;
        int          lat;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];

    truth_table_probe_if b1();
    truth_table_probe_if b3();

    truth_table_probe #(.SETTLE(1)) dut1 (.clk(clk), .areset_n(areset_n), .bus(b1.slave));
    truth_table_probe #(.SETTLE(3)) dut3 (.clk(clk), .areset_n(areset_n), .bus(b3.slave));

    assign b1.f = (fmode1 == 0) ? ref_tbl[b1.x] : (fmode1 == 1) ? 1'b0 : 1'b1;
    assign b3.f = ref_tbl[b3.x];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_result(input string tag, input exp_t e,
                                input logic [15:0] tbl, input logic [4:0] cnt,
                                input logic mm, input logic [3:0] fb,
                                input logic busy, input logic [3:0] x);
        chk({tag, " table"}, 32'(tbl), 32'(e.tbl));
        chk({tag, " mismatch_cnt"}, 32'(cnt), 32'(e.cnt));
        chk({tag, " mismatch"}, 32'(mm), 32'(e.cnt != 5'd0));
        chk({tag, " first_bad"}, 32'(fb), 32'(e.fb));
        chk({tag, " busy in done"}, 32'(busy), 32'd0);
        chk({tag, " x in done"}, 32'(x), 32'd0);
        chk({tag, " latency"}, 32'(cyc - e.start_cyc), 32'(e.lat));
    endtask

    always @(negedge clk) begin
        if (areset_n && b1.done) begin
            if (q1.size() == 0) chk("dut1 unexpected done", 32'd1, 32'd0);
            else check_result("dut1", q1.pop_front(), b1.truth_tbl, b1.mismatch_cnt,
                              b1.mismatch, b1.first_bad, b1.busy, b1.x);
        end
    end

    always @(negedge clk) begin
        if (areset_n && b3.done) begin
            if (q3.size() == 0) chk("dut3 unexpected done", 32'd1, 32'd0);
            else check_result("dut3", q3.pop_front(), b3.truth_tbl, b3.mismatch_cnt,
                              b3.mismatch, b3.first_bad, b3.busy, b3.x);
        end
    end

    task automatic wait_q1(input int limit);
        int n = 0;
        while (q1.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("dut1 done timeout", 32'(q1.size()), 32'd0);
        @(negedge clk);
    endtask

    // Call just after a negedge: pulses start on dut1 and queues the expected result.
    task automatic sweep1(input logic [15:0] e, input int fm,
                          input logic [15:0] tbl, input logic [4:0] cnt, input logic [3:0] fb);
        fmode1 = fm;
        b1.expected = e;
        b1.start = 1'b1;
        @(posedge clk);
        #1;
        b1.start = 1'b0;
        q1.push_back('{tbl: tbl, cnt: cnt, fb: fb, start_cyc: cyc, lat: 16});
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " x"}, 32'(b1.x), 32'd0);
        chk({tag, " busy"}, 32'(b1.busy), 32'd0);
        chk({tag, " done"}, 32'(b1.done), 32'd0);
        chk({tag, " table"}, 32'(b1.truth_tbl), 32'd0);
        chk({tag, " mismatch_cnt"}, 32'(b1.mismatch_cnt), 32'd0);
        chk({tag, " mismatch"}, 32'(b1.mismatch), 32'd0);
        chk({tag, " first_bad"}, 32'(b1.first_bad), 32'd0);
        chk({tag, " dut3 busy"}, 32'(b3.busy), 32'd0);
        chk({tag, " dut3 table"}, 32'(b3.truth_tbl), 32'd0);
    endtask

    initial begin
        int s0;
        b1.start = 1'b0;
        b1.expected = 16'h0;
        b3.start = 1'b0;
        b3.expected = 16'h0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        areset_n = 1'b1;
        @(negedge clk);

        sweep1(16'hD073, 0, 16'hD073, 5'd0, 4'd0);  wait_q1(40);
        sweep1(16'hD072, 0, 16'hD073, 5'd1, 4'd0);  wait_q1(40);
        sweep1(16'h5073, 0, 16'hD073, 5'd1, 4'd15); wait_q1(40);
        sweep1(16'hFFFF, 1, 16'h0000, 5'd16, 4'd0); wait_q1(40);
        chk("results held in idle", 32'(b1.mismatch_cnt), 32'd16);
        sweep1(16'h0000, 2, 16'hFFFF, 5'd16, 4'd0); wait_q1(40);

        // Extra start pulses and a changed expected mid-sweep must not disturb it.
        sweep1(16'hD073, 0, 16'hD073, 5'd0, 4'd0);
        repeat (4) @(negedge clk);
        b1.start = 1'b1;
        b1.expected = 16'h0000;
        @(negedge clk);
        b1.start = 1'b0;
        repeat (9) @(negedge clk);
        b1.start = 1'b1;
        @(negedge clk);
        b1.start = 1'b0;
        wait_q1(40);

        // Start held high: a second sweep begins on the first IDLE edge after DONE.
        fmode1 = 0;
        b1.expected = 16'h5073;
        b1.start = 1'b1;
        @(posedge clk);
        #1;
        s0 = cyc;
        q1.push_back('{tbl: 16'hD073, cnt: 5'd1, fb: 4'd15, start_cyc: s0, lat: 16});
        q1.push_back('{tbl: 16'hD073, cnt: 5'd1, fb: 4'd15, start_cyc: s0 + 18, lat: 16});
        repeat (20) @(negedge clk);
        b1.start = 1'b0;
        wait_q1(40);

        // SETTLE=3: each x held three cycles, in order, no gaps.
        b3.expected = 16'hD071;
        b3.start = 1'b1;
        @(posedge clk);
        #1;
        b3.start = 1'b0;
        q3.push_back('{tbl: 16'hD073, cnt: 5'd1, fb: 4'd1, start_cyc: cyc, lat: 48});
        for (int k = 0; k < 16; k++) begin
            for (int r = 0; r < 3; r++) begin
                @(negedge clk);
                chk("dut3 x sequence", 32'(b3.x), 32'(k));
            end
        end
        repeat (4) @(negedge clk);
        chk("dut3 done count", 32'(q3.size()), 32'd0);

        // Reset mid-sweep aborts with no done; release with start high is honoured.
        @(negedge clk);
        fmode1 = 0;
        b1.expected = 16'h0000;
        b1.start = 1'b1;
        @(posedge clk);
        #1;
        b1.start = 1'b0;
        repeat (6) @(negedge clk);
        areset_n = 1'b0;
        #1;
        check_zero("abort");
        repeat (2) @(negedge clk);
        areset_n = 1'b1;
        sweep1(16'hD073, 0, 16'hD073, 5'd0, 4'd0);
        wait_q1(40);

        repeat (5) @(negedge clk);
        chk("dut1 pending results", 32'(q1.size()), 32'd0);
        chk("dut3 pending results", 32'(q3.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/truth_table_probe.md
TRUTH_TABLE_PROBE -- requirements
Module: truth_table_probe

Interface
REQ-001 Parameter SETTLE, default 1, number of clock cycles each x value is held before f is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 areset_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a full sweep; honoured only in IDLE.
REQ-005 expected  input  16  golden truth table; bit i is the expected f for x=i; latched on start.
REQ-006 f  input  1  response of the 4-input combinational function under test.
REQ-007 x  output  4  stimulus driven to the function under test.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  one-cycle pulse when a sweep completes.
REQ-010 table  output  16  captured truth table; bit i is f sampled while x=i.
REQ-011 mismatch_cnt  output  5  count of indices where table differs from the latched expected value, 0..16.
REQ-012 mismatch  output  1  high when mismatch_cnt is nonzero.
REQ-013 first_bad  output  4  lowest mismatching index; 0 when mismatch is low.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In IDLE, with start high at an edge, the block SHALL:
- latch expected;
- clear table, mismatch_cnt and first_bad;
- set x=0 and the wait counter to SETTLE;
- set busy=1 and enter RUN.
REQ-016 In RUN, while the wait counter is greater than 1, each edge SHALL decrement it and leave x unchanged.
REQ-017 In RUN, when the wait counter equals 1, the edge SHALL:
- write f into table[x];
- if f differs from expected[x], increment mismatch_cnt;
- if f differs and this is the first mismatch of the sweep, load x into first_bad.
REQ-018 On that same edge, if x<15 the block SHALL increment x and reload the wait counter with SETTLE.
REQ-019 On that same edge, if x==15 the block SHALL enter DONE.
REQ-020 Each x value SHALL be held for exactly SETTLE cycles, and x SHALL never wrap from 15 to 0 within a sweep.
REQ-021 The final result SHALL be visible at the edge 16*SETTLE edges after the start edge, with done=1 and busy=0 in the following cycle.
REQ-022 DONE SHALL last one cycle (done=1, busy=0, x=0) and then return to IDLE.
REQ-023 table, mismatch_cnt, mismatch and first_bad SHALL hold their values in IDLE until the next accepted start.
REQ-024 start SHALL be ignored in RUN and DONE; start held high continuously SHALL begin a new sweep on the first IDLE edge after DONE.
REQ-025 A change on expected after the start edge SHALL NOT affect the results of the sweep in progress.
REQ-026 mismatch SHALL be derived combinationally from mismatch_cnt (nonzero test); all other outputs SHALL be registered.
REQ-027 mismatch_cnt SHALL saturate naturally at 16 (5-bit width, no overflow possible); table bit order SHALL be LSB = index 0.

Reset
REQ-028 While areset_n is low, the block SHALL be in IDLE with all outputs zero: x=0, busy=0, done=0, table=0, mismatch_cnt=0, mismatch=0, first_bad=0, and latched expected=0.
REQ-029 Reset asserted during RUN SHALL abort the sweep immediately with no done pulse; the first start after release SHALL perform a complete fresh sweep.
REQ-030 Release of reset SHALL take effect at the next clk edge, and start sampled on that edge SHALL be honoured.

Verification
REQ-031 SETTLE=1, f driven by the reference function with table 0xD073, expected=0xD073, start pulse -> done 16 cycles after the start edge, table=0xD073, mismatch_cnt=0, first_bad=0.
REQ-032 Same DUT, expected=0xD072 -> mismatch_cnt=1, mismatch=1, first_bad=0; with expected=0x5073 -> mismatch_cnt=1, first_bad=15.
REQ-033 f tied 0, expected=0xFFFF -> table=0x0000, mismatch_cnt=16, first_bad=0; f tied 1, expected=0x0000 -> table=0xFFFF, mismatch_cnt=16.
REQ-034 SETTLE=3 -> each x value stable for exactly 3 cycles, x sequence 0..15 with no gaps or repeats, done 48 cycles after the start edge.
REQ-035 start pulsed again at cycles 5 and 15 of a sweep, and expected changed mid-sweep -> single done pulse, results match the originally latched expected.
REQ-036 areset_n low at cycle 7 of a sweep -> all outputs 0 immediately and no done pulse; a new start then yields the full correct 0xD073 result.
